// File: rtl/i2c_slv_pkg.sv
// i2c_slv_pkg: shared controller state type and constants for the I2C slave register controller.
//   state_t      : controller FSM states
//   NUM_REGS_DEF : default register count
//   REG_AW       : register index width for the default register count
//   ACK / NACK   : values driven on the acknowledge output
package i2c_slv_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, PTR, WDATA, RDATA, IGNORE} state_t;
    localparam int NUM_REGS_DEF = 16;
    localparam int REG_AW = $clog2(NUM_REGS_DEF);
    localparam logic ACK = 1'b1;
    localparam logic NACK = 1'b0;
endpackage

// File: rtl/i2c_slv_reg_ctrl_if.sv
// i2c_slv_reg_ctrl_if: bus bundle between the slave FSM / local host and the register controller.
//   I2C side : I_ADDR_SLV, I_RW, I_DATA_RD, I_BYTE_STB, I_TX_REQ, I_ACK_MSTR, I_BUSY -> O_ACK, O_TX_DATA, O_WR_IRQ
//   Host side: I_HOST_REQ, I_HOST_WE, I_HOST_ADDR, I_HOST_WDATA -> O_HOST_GNT, O_HOST_RDATA
//   master modport drives the inputs, slave modport is the controller.
interface i2c_slv_reg_ctrl_if import i2c_slv_pkg::*; #(
    parameter int DATA_SZ  = 8,
    parameter int NUM_REGS = NUM_REGS_DEF
);
    logic [DATA_SZ-2:0]          I_ADDR_SLV;
    logic                        I_RW;
    logic [DATA_SZ-1:0]          I_DATA_RD;
    logic                        I_BYTE_STB;
    logic                        I_TX_REQ;
    logic                        I_ACK_MSTR;
    logic                        I_BUSY;
    logic                        O_ACK;
    logic [DATA_SZ-1:0]          O_TX_DATA;
    logic                        O_WR_IRQ;
    logic                        I_HOST_REQ;
    logic                        I_HOST_WE;
    logic [$clog2(NUM_REGS)-1:0] I_HOST_ADDR;
    logic [DATA_SZ-1:0]          I_HOST_WDATA;
    logic                        O_HOST_GNT;
    logic [DATA_SZ-1:0]          O_HOST_RDATA;
    modport master (
        output I_ADDR_SLV, I_RW, I_DATA_RD, I_BYTE_STB, I_TX_REQ, I_ACK_MSTR, I_BUSY,
        output I_HOST_REQ, I_HOST_WE, I_HOST_ADDR, I_HOST_WDATA,
        input  O_ACK, O_TX_DATA, O_WR_IRQ, O_HOST_GNT, O_HOST_RDATA
    );
    modport slave (
        input  I_ADDR_SLV, I_RW, I_DATA_RD, I_BYTE_STB, I_TX_REQ, I_ACK_MSTR, I_BUSY,
        input  I_HOST_REQ, I_HOST_WE, I_HOST_ADDR, I_HOST_WDATA,
        output O_ACK, O_TX_DATA, O_WR_IRQ, O_HOST_GNT, O_HOST_RDATA
    );
endinterface

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: NUM_REGS x DATA_SZ register bank, one synchronous write port, two registered read ports.
//   CLK, RST_n                 : clock, async active-low reset (clears all registers and read data)
//   i_we, i_waddr, i_wdata     : write port
//   i_re_a, i_raddr_a, o_rdata_a : I2C read port, data updates only when enabled
//   i_re_b, i_raddr_b, o_rdata_b : host read port, data updates only when enabled
module i2c_reg_bank #(
    parameter int DATA_SZ  = 8,
    parameter int NUM_REGS = 16,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [DATA_SZ-1:0] i_wdata,
    input  logic               i_re_a,
    input  logic [AW-1:0]      i_raddr_a,
    output logic [DATA_SZ-1:0] o_rdata_a,
    input  logic               i_re_b,
    input  logic [AW-1:0]      i_raddr_b,
    output logic [DATA_SZ-1:0] o_rdata_b
);
    logic [DATA_SZ-1:0] r_mem [NUM_REGS];
    logic [DATA_SZ-1:0] r_rd_a, r_rd_b;
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
            if (i_re_a) r_rd_a <= r_mem[i_raddr_a];
            if (i_re_b) r_rd_b <= r_mem[i_raddr_b];
        end
    end
    assign o_rdata_a = r_rd_a;
    assign o_rdata_b = r_rd_b;
endmodule

// File: rtl/i2c_slv_reg_ctrl.sv
// i2c_slv_reg_ctrl: I2C slave register-map controller with auto-incrementing pointer and host port.
//   CLK, RST_n : system clock, async active-low reset
//   s_if       : slave modport of i2c_slv_reg_ctrl_if (I2C byte/ACK/TX signals, host request port, write IRQ)
//   O_ACK and O_WR_IRQ are registered; O_HOST_GNT is combinational (zero-latency when uncontended).
module i2c_slv_reg_ctrl import i2c_slv_pkg::*; #(
    parameter int                 FPGA_CLK = 50_000_000,
    parameter int                 DATA_SZ  = 8,
    parameter logic [DATA_SZ-2:0] SLV_ADDR = 7'h42,
    parameter int                 NUM_REGS = NUM_REGS_DEF
) (
    input  logic CLK,
    input  logic RST_n,
    i2c_slv_reg_ctrl_if.slave s_if
);
    localparam int AW = $clog2(NUM_REGS);
    if (FPGA_CLK <= 0 || NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_cfg
        $error("i2c_slv_reg_ctrl: unsupported FPGA_CLK/NUM_REGS");
    end
    state_t             r_state;
    logic               r_busy, r_ack, r_irq;
    logic [AW-1:0]      r_ptr;
    logic               w_stb, w_addr_stb, w_hit, w_ptr_ok, w_i2c_we, w_i2c_re, w_gnt;
    logic [AW-1:0]      w_waddr;
    logic [DATA_SZ-1:0] w_wdata;
    assign w_stb    = s_if.I_BYTE_STB & s_if.I_BUSY;
    // A strobe is an address byte in ADDR, and also a repeated START where no data strobe can occur:
    // RDATA never sees data strobes, and in the write phases the slave FSM only reports R/W=1 after a new address.
    assign w_addr_stb = w_stb & (r_state == ADDR || r_state == RDATA ||
                                 ((r_state == PTR || r_state == WDATA) && s_if.I_RW));
    assign w_hit    = s_if.I_ADDR_SLV == SLV_ADDR;
    assign w_ptr_ok = int'(s_if.I_DATA_RD) < NUM_REGS;
    assign w_i2c_we = w_stb & ~w_addr_stb & (r_state == WDATA);
    assign w_i2c_re = s_if.I_TX_REQ & s_if.I_BUSY & (r_state == RDATA);
    // I2C owns the bank in any cycle it touches it; the held host request wins the following cycle.
    assign w_gnt    = s_if.I_HOST_REQ & ~(w_i2c_we | w_i2c_re) & RST_n;
    assign w_waddr  = w_i2c_we ? r_ptr : s_if.I_HOST_ADDR;
    assign w_wdata  = w_i2c_we ? s_if.I_DATA_RD : s_if.I_HOST_WDATA;
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_ack   <= NACK;
            r_irq   <= 1'b0;
        end else begin
            r_busy <= s_if.I_BUSY;
            r_irq  <= w_i2c_we;
            if (!s_if.I_BUSY) begin
                r_state <= IDLE;
                r_ack   <= NACK;
            end else if (r_state == IDLE) begin
                if (!r_busy) r_state <= ADDR;
            end else if (w_addr_stb) begin
                r_ack   <= w_hit ? ACK : NACK;
                r_state <= !w_hit ? IGNORE : s_if.I_RW ? RDATA : PTR;
            end else if (w_stb) begin
                if (r_state == PTR && w_ptr_ok) begin
                    r_ptr   <= s_if.I_DATA_RD[AW-1:0];
                    r_ack   <= ACK;
                    r_state <= WDATA;
                end else if (r_state == WDATA) begin
                    r_ptr <= r_ptr + 1'b1;
                    r_ack <= ACK;
                end else begin
                    r_ack   <= NACK;
                    r_state <= IGNORE;
                end
            end else if (w_i2c_re) begin
                r_ptr <= r_ptr + 1'b1;
                if (!s_if.I_ACK_MSTR) r_state <= IGNORE;
            end
        end
    end
    i2c_reg_bank #(.DATA_SZ(DATA_SZ), .NUM_REGS(NUM_REGS)) u_bank (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .i_we      (w_i2c_we | (w_gnt & s_if.I_HOST_WE)),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_re_a    (w_i2c_re),
        .i_raddr_a (r_ptr),
        .o_rdata_a (s_if.O_TX_DATA),
        .i_re_b    (w_gnt & ~s_if.I_HOST_WE),
        .i_raddr_b (s_if.I_HOST_ADDR),
        .o_rdata_b (s_if.O_HOST_RDATA)
    );
    assign s_if.O_ACK      = r_ack;
    assign s_if.O_WR_IRQ   = r_irq;
    assign s_if.O_HOST_GNT = w_gnt;
endmodule
